// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP states, ID code, scan scheduler state encoding and defaults.
package jtag_pkg;

  localparam int          JTAG_N_CH           = 18;
  localparam int          JTAG_TIMEOUT_CYCLES = 256;
  localparam logic [31:0] ID_CODE             = 32'h1BA0_0477;

  typedef enum logic [3:0] {
    TAP_RESET, TAP_IDLE, TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR,
    TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR,
    TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
  } tap_state_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_SETTLE, ST_ENG_RST, ST_RUN, ST_RECORD, ST_NEXT, ST_FINISH
  } scan_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jtag_scan_timer.sv
// Loadable down-counter; tc is high while the count is zero.
module jtag_scan_timer #(
  parameter int W = 8
) (
  input  logic         tck,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/jtag_scan_scheduler.sv
// Walks the shared JTAG boot-config engine over every enabled mezzanine channel.
// Optional JTAG_SCAN_RETRY_EN: a failed or timed-out channel gets one more attempt.
module jtag_scan_scheduler import jtag_pkg::*; #(
  parameter int N_CH           = JTAG_N_CH,
  parameter int SETTLE_CYCLES  = 4,
  parameter int ENG_RST_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = JTAG_TIMEOUT_CYCLES
) (
  input  logic                                tck,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [N_CH-1:0]                     enable_mask,
  input  logic                                eng_done,
  input  logic                                eng_pf,
  output logic [((N_CH>1)?$clog2(N_CH):1)-1:0] chan_sel,
  output logic                                eng_rst,
  output logic                                busy,
  output logic                                scan_done,
  output logic [N_CH-1:0]                     present_mask,
  output logic [N_CH-1:0]                     timeout_mask
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW = $clog2(max3(SETTLE_CYCLES, ENG_RST_CYCLES, TIMEOUT_CYCLES) + 1);

  scan_state_t     state;
  logic [N_CH-1:0] en_q;
  logic            pass_q, to_q;
  logic            tmr_load, tmr_tc;
  logic [TW-1:0]   tmr_val;
  logic            accept, do_retry;

  // FINISH already reports not-busy, so a start landing there is honoured too
  assign busy      = (state != ST_IDLE) && (state != ST_FINISH);
  assign scan_done = (state == ST_FINISH);
  assign eng_rst   = (state != ST_RUN);
  assign accept    = start && !busy;

`ifdef JTAG_SCAN_RETRY_EN
  logic retry_q;

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n)                 retry_q <= 1'b0;
    else if (state == ST_SELECT) retry_q <= 1'b0;
    else if (do_retry)          retry_q <= 1'b1;
  end

  assign do_retry = (state == ST_RECORD) && !pass_q && !retry_q;
`else
  assign do_retry = 1'b0;
`endif

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_SELECT:  if (en_q[chan_sel]) begin tmr_load = 1'b1; tmr_val = TW'(SETTLE_CYCLES - 1);  end
      ST_SETTLE:  if (tmr_tc)         begin tmr_load = 1'b1; tmr_val = TW'(ENG_RST_CYCLES - 1); end
      ST_ENG_RST: if (tmr_tc)         begin tmr_load = 1'b1; tmr_val = TW'(TIMEOUT_CYCLES - 1); end
      ST_RECORD:  if (do_retry)       begin tmr_load = 1'b1; tmr_val = TW'(SETTLE_CYCLES - 1);  end
      default: ;
    endcase
  end

  jtag_scan_timer #(.W(TW)) u_timer (
    .tck      (tck),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      chan_sel     <= '0;
      en_q         <= '0;
      present_mask <= '0;
      timeout_mask <= '0;
      pass_q       <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_FINISH: begin
          if (accept) begin
            en_q         <= enable_mask;
            present_mask <= '0;
            timeout_mask <= '0;
            chan_sel     <= '0;
            state        <= ST_SELECT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SELECT:  state <= en_q[chan_sel] ? ST_SETTLE : ST_NEXT;
        ST_SETTLE:  if (tmr_tc) state <= ST_ENG_RST;
        ST_ENG_RST: if (tmr_tc) state <= ST_RUN;
        ST_RUN: begin
          // a done seen on the timeout cycle still counts as done
          if (eng_done) begin
            pass_q <= eng_pf;
            to_q   <= 1'b0;
            state  <= ST_RECORD;
          end else if (tmr_tc) begin
            pass_q <= 1'b0;
            to_q   <= 1'b1;
            state  <= ST_RECORD;
          end
        end
        ST_RECORD: begin
          present_mask[chan_sel] <= pass_q;
          timeout_mask[chan_sel] <= to_q;
          state                  <= do_retry ? ST_SETTLE : ST_NEXT;
        end
        ST_NEXT: begin
          if (chan_sel == IW'(N_CH - 1)) begin
            state <= ST_FINISH;
          end else begin
            chan_sel <= chan_sel + 1'b1;
            state    <= ST_SELECT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
